cfa_cross_window: RTL and testbench

Raster-to-neighbourhood stage placed directly upstream of the green interpolation stage. It accepts a Bayer CFA pixel stream in raster order and holds four previous lines in line buffers. For every interior centre pixel it emits the 9-pixel cross neighbourhood in one registered beat: the centre, plus ±1 and ±2 vertically and horizontally. Borders are not padded; output frame size is (IMG_W-4) x (IMG_H-4).

---
 rtl/cfa_cross_window.sv | 132 +++++++++++++
 tb/tb_cfa_cross_window.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfa_cross_window.sv
// Raster-to-cross-neighbourhood stage: four line buffers plus small alignment
// registers turn a Bayer CFA raster stream into registered 9-pixel cross windows.
module cfa_cross_window #(
  parameter int PIXEL_BW = 12,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 48,
  parameter int COL_BW   = $clog2(IMG_W),
  parameter int ROW_BW   = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [PIXEL_BW-1:0] in_pixel,
  output logic                out_valid,
  output logic                out_sof,
  output logic                out_eol,
  output logic [ROW_BW-1:0]   out_row,
  output logic [COL_BW-1:0]   out_col,
  output logic [PIXEL_BW-1:0] p_m2_p0,
  output logic [PIXEL_BW-1:0] p_m1_p0,
  output logic [PIXEL_BW-1:0] p_p0_m2,
  output logic [PIXEL_BW-1:0] p_p0_m1,
  output logic [PIXEL_BW-1:0] p_p0_p0,
  output logic [PIXEL_BW-1:0] p_p0_p1,
  output logic [PIXEL_BW-1:0] p_p0_p2,
  output logic [PIXEL_BW-1:0] p_p1_p0,
  output logic [PIXEL_BW-1:0] p_p2_p0
);

  typedef logic [PIXEL_BW-1:0] pix_t;

  // Vertical taps that only need the 2-column delay (row r-2 has its own window).
  typedef struct packed {
    pix_t m4;
    pix_t m3;
    pix_t m1;
    pix_t p0;
  } vtap_t;

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t lb2 [IMG_W];
  pix_t lb3 [IMG_W];

  logic [COL_BW-1:0] col, cur_col;
  logic [ROW_BW-1:0] row, cur_row;
  logic              accept, emit, at_first, at_eol;
  vtap_t             v_now, v_d1, v_d2;
  pix_t              tap_m2;
  // Row r-2 history: hsr[0] is column c-1, hsr[3] is column c-4.
  logic [3:0][PIXEL_BW-1:0] hsr;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    accept   = in_valid && !rst;
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    tap_m2   = lb1[cur_col];
    v_now    = {lb3[cur_col], lb2[cur_col], lb0[cur_col], in_pixel};
    emit     = accept && (cur_row >= ROW_BW'(4)) && (cur_col >= COL_BW'(4));
    at_first = (cur_row == ROW_BW'(4)) && (cur_col == COL_BW'(4));
    at_eol   = (cur_col == COL_BW'(IMG_W - 1));
  end

  // NOTE: line buffers carry no reset; rows 0-3 of each frame refill them before
  // any emission reads them, so clearing would only cost a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= in_pixel;
      lb1[cur_col] <= lb0[cur_col];
      lb2[cur_col] <= lb1[cur_col];
      lb3[cur_col] <= lb2[cur_col];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which the read-before-write chain depends on.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      v_d1      <= '0;
      v_d2      <= '0;
      hsr       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      p_m2_p0   <= '0;
      p_m1_p0   <= '0;
      p_p0_m2   <= '0;
      p_p0_m1   <= '0;
      p_p0_p0   <= '0;
      p_p0_p1   <= '0;
      p_p0_p2   <= '0;
      p_p1_p0   <= '0;
      p_p2_p0   <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && at_first;
      out_eol   <= emit && at_eol;
      if (emit) begin
        out_row <= cur_row - ROW_BW'(2);
        out_col <= cur_col - COL_BW'(2);
        p_m2_p0 <= v_d2.m4;
        p_m1_p0 <= v_d2.m3;
        p_p0_m2 <= hsr[3];
        p_p0_m1 <= hsr[2];
        p_p0_p0 <= hsr[1];
        p_p0_p1 <= hsr[0];
        p_p0_p2 <= tap_m2;
        p_p1_p0 <= v_d2.m1;
        p_p2_p0 <= v_d2.p0;
      end
      if (in_valid) begin
        if (at_eol) begin
          col <= '0;
          row <= (cur_row == ROW_BW'(IMG_H - 1)) ? '0 : cur_row + ROW_BW'(1);
        end else begin
          col <= cur_col + COL_BW'(1);
          row <= cur_row;
        end
        v_d1 <= v_now;
        v_d2 <= v_d1;
        hsr  <= {hsr[2:0], tap_m2};
      end
    end
  end

endmodule

// File: tb/tb_cfa_cross_window.sv
// Directed bench for cfa_cross_window on an 8x6 frame: ramp, gaps, back-to-back,
// mid-frame sof and reset, and full-scale pixel values.
module tb_cfa_cross_window;

  localparam int PW = 12;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CB = 3;
  localparam int RB = 3;

  localparam int DR [9] = '{-2, -1, 0, 0, 0, 0, 0, 1, 2};
  localparam int DC [9] = '{0, 0, -2, -1, 0, 1, 2, 0, 0};

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid, out_sof, out_eol;
  logic [RB-1:0] out_row;
  logic [CB-1:0] out_col;
  logic [PW-1:0] p_m2_p0, p_m1_p0, p_p0_m2, p_p0_m1, p_p0_p0;
  logic [PW-1:0] p_p0_p1, p_p0_p2, p_p1_p0, p_p2_p0;

  int            checks = 0;
  int            failures = 0;
  logic [PW-1:0] exp_hold = '0;
  string         tap_name [9] = '{"p_m2_p0", "p_m1_p0", "p_p0_m2", "p_p0_m1", "p_p0_p0",
                                  "p_p0_p1", "p_p0_p2", "p_p1_p0", "p_p2_p0"};

  always #5 clk = ~clk;

  cfa_cross_window #(.PIXEL_BW(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
    .out_row(out_row), .out_col(out_col),
    .p_m2_p0(p_m2_p0), .p_m1_p0(p_m1_p0),
    .p_p0_m2(p_p0_m2), .p_p0_m1(p_p0_m1), .p_p0_p0(p_p0_p0),
    .p_p0_p1(p_p0_p1), .p_p0_p2(p_p0_p2),
    .p_p1_p0(p_p1_p0), .p_p2_p0(p_p2_p0)
  );

  // Drive one cycle of inputs and return just after the capturing edge.
  task automatic step(input logic v, input logic s, input logic r, input logic [PW-1:0] px);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    rst      = r;
    in_pixel = px;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pix(input bit sat, input logic [PW-1:0] base,
                                        input int r, input int c);
    if (sat) return (r == 2 && c == 2) ? 12'h000 : 12'hFFF;
    return base + PW'(r * 16 + c);
  endfunction

  // Streams npix pixels of a frame from (0,0) and checks every cycle's outputs.
  task automatic ramp_frame(input bit sat, input logic [PW-1:0] base, input int idle_pct,
                            input bit sof_first, input int npix,
                            output int n_emit, output int n_sof, output int n_eol);
    int            k;
    bit            emit;
    logic [PW-1:0] act [9];
    logic [PW-1:0] expv;
    k = 0;
    n_emit = 0;
    n_sof = 0;
    n_eol = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k == npix) return;
        while ($urandom_range(99) < idle_pct) begin
          step(1'b0, 1'($urandom_range(1)), 1'b0, PW'($urandom));
          n_emit += int'(out_valid);
          checks++;
          if (out_valid !== 1'b0 || p_p0_p0 !== exp_hold) begin
            failures++;
            $display("FAIL idle_hold: valid=%0b centre=%03h, required valid=0 centre=%03h",
                     out_valid, p_p0_p0, exp_hold);
          end
        end
        step(1'b1, sof_first && k == 0, 1'b0, pix(sat, base, r, c));
        k++;
        emit = (r >= 4) && (c >= 4);
        n_emit += int'(out_valid);
        n_sof  += int'(out_sof);
        n_eol  += int'(out_eol);
        checks++;
        if (out_valid !== emit) begin
          failures++;
          $display("FAIL out_valid at (%0d,%0d): got %0b required %0b", r, c, out_valid, emit);
        end
        if (emit) begin
          checks++;
          if (out_row !== RB'(r - 2) || out_col !== CB'(c - 2) ||
              out_sof !== (r == 4 && c == 4) || out_eol !== (c == W - 1)) begin
            failures++;
            $display("FAIL coords at (%0d,%0d): row=%0d col=%0d sof=%0b eol=%0b, required %0d %0d %0b %0b",
                     r, c, out_row, out_col, out_sof, out_eol, r - 2, c - 2,
                     (r == 4 && c == 4), (c == W - 1));
          end
          act = '{p_m2_p0, p_m1_p0, p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2, p_p1_p0, p_p2_p0};
          for (int t = 0; t < 9; t++) begin
            expv = pix(sat, base, r - 2 + DR[t], c - 2 + DC[t]);
            checks++;
            if (act[t] !== expv) begin
              failures++;
              $display("FAIL %s at centre (%0d,%0d): got %03h required %03h",
                       tap_name[t], r - 2, c - 2, act[t], expv);
            end
          end
          exp_hold = pix(sat, base, r - 2, c - 2);
        end else begin
          checks++;
          if (p_p0_p0 !== exp_hold) begin
            failures++;
            $display("FAIL hold at (%0d,%0d): centre=%03h required %03h", r, c, p_p0_p0, exp_hold);
          end
        end
      end
    end
  endtask

  task automatic check_counts(input string name, input int ne, input int ns, input int nl,
                              input int ee, input int es, input int el);
    checks++;
    if (ne !== ee || ns !== es || nl !== el) begin
      failures++;
      $display("FAIL %s counts: emit=%0d sof=%0d eol=%0d, required %0d %0d %0d",
               name, ne, ns, nl, ee, es, el);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({out_valid, out_sof, out_eol, out_row, out_col} !== '0) begin
      failures++;
      $display("FAIL %s ctrl: valid=%0b sof=%0b eol=%0b row=%0d col=%0d, required all 0",
               name, out_valid, out_sof, out_eol, out_row, out_col);
    end
    checks++;
    if ({p_m2_p0, p_m1_p0, p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2, p_p1_p0, p_p2_p0} !== '0) begin
      failures++;
      $display("FAIL %s taps: centre=%03h top=%03h bottom=%03h, required all 0",
               name, p_p0_p0, p_m2_p0, p_p2_p0);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1, 12'hABC);
    step(1'b1, 1'b1, 1'b1, 12'h123);
    check_zero("reset");
    exp_hold = '0;
    step(1'b0, 1'b0, 1'b0, '0);
    check_zero("post_reset_idle");
  endtask

  task automatic test_ramp();
    int ne, ns, nl;
    ramp_frame(1'b0, 12'h000, 0, 1'b1, W * H, ne, ns, nl);
    check_counts("ramp", ne, ns, nl, 8, 1, 2);
  endtask

  task automatic test_gaps();
    int ne, ns, nl;
    ramp_frame(1'b0, 12'h000, 40, 1'b1, W * H, ne, ns, nl);
    check_counts("gaps", ne, ns, nl, 8, 1, 2);
  endtask

  task automatic test_back_to_back();
    int ne, ns, nl;
    ramp_frame(1'b0, 12'h000, 0, 1'b1, W * H, ne, ns, nl);
    check_counts("b2b_frame1", ne, ns, nl, 8, 1, 2);
    ramp_frame(1'b0, 12'h100, 0, 1'b0, W * H, ne, ns, nl);
    check_counts("b2b_frame2", ne, ns, nl, 8, 1, 2);
  endtask

  task automatic test_sof_restart();
    int ne, ns, nl;
    ramp_frame(1'b0, 12'h200, 0, 1'b1, 3 * W + 2, ne, ns, nl);
    check_counts("sof_partial", ne, ns, nl, 0, 0, 0);
    ramp_frame(1'b0, 12'h000, 0, 1'b1, W * H, ne, ns, nl);
    check_counts("sof_restart", ne, ns, nl, 8, 1, 2);
  endtask

  task automatic test_rst_mid();
    int ne, ns, nl;
    ramp_frame(1'b0, 12'h300, 0, 1'b1, 5 * W + 5, ne, ns, nl);
    check_counts("rst_partial", ne, ns, nl, 5, 1, 1);
    step(1'b1, 1'b0, 1'b1, pix(1'b0, 12'h300, 5, 5));
    check_zero("rst_mid");
    exp_hold = '0;
    ramp_frame(1'b0, 12'h000, 0, 1'b0, W * H, ne, ns, nl);
    check_counts("rst_restart", ne, ns, nl, 8, 1, 2);
  endtask

  task automatic test_saturate();
    int ne, ns, nl;
    ramp_frame(1'b1, 12'h000, 0, 1'b1, W * H, ne, ns, nl);
    check_counts("saturate", ne, ns, nl, 8, 1, 2);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pixel = '0;
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_sof_restart();
    test_rst_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
